// File: rtl/dmac_apb_slave_if.sv
// APB3 slave front-end for the DMAC register block: decodes, inserts wait states, issues
// single-cycle register strobes. Optional write protection via `DMAC_APB_WRPROT_EN (adds lock_i).
module dmac_apb_slave_if #(
  parameter int ADDR_W      = 12,
  parameter int NUM_REGS    = 4,
  parameter int WAIT_CYCLES = 0,
  localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [31:0]       pwdata_i,
  output logic [31:0]       prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  output logic [IDX_W-1:0]  reg_idx_o,
  output logic              reg_wren_o,
  output logic              reg_rden_o,
  output logic [31:0]       reg_wdata_o,
`ifdef DMAC_APB_WRPROT_EN
  input  logic              lock_i,
`endif
  input  logic [31:0]       reg_rdata_i
);

  localparam int WA_W = ADDR_W - 2;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_STRB,
    S_CAPT,
    S_DONE,
    S_ERR
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             write_q, write_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      prdata_q, prdata_d;

  logic [WA_W-1:0]  word_addr;
  logic             dec_err;
  logic             wr_locked;

  assign word_addr = paddr_i[ADDR_W-1:2];
  assign dec_err   = (paddr_i[1:0] != 2'b00) || (word_addr >= WA_W'(NUM_REGS));

`ifdef DMAC_APB_WRPROT_EN
  assign wr_locked = pwrite_i & lock_i;
`else
  assign wr_locked = 1'b0;
`endif

  // rst_n is active-high and asynchronous in this codebase despite its name
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      prdata_q <= prdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    prdata_d = prdata_q;
    unique case (state_q)
      S_IDLE: begin
        // an access phase without a preceding setup phase is deliberately ignored
        if (psel_i && !penable_i) begin
          idx_d   = word_addr[IDX_W-1:0];
          write_d = pwrite_i;
          wdata_d = pwdata_i;
          if (dec_err || wr_locked) begin
            state_d = S_ERR;
          end else if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = S_STRB;
          end
        end
      end
      S_WAIT: begin
        if (!psel_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_STRB;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_STRB: state_d = write_q ? S_DONE : S_CAPT;
      S_CAPT: begin
        prdata_d = reg_rdata_i;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign reg_wren_o  = (state_q == S_STRB) && write_q;
  assign reg_rden_o  = (state_q == S_STRB) && !write_q;
  assign reg_idx_o   = idx_q;
  assign reg_wdata_o = wdata_q;
  assign pready_o    = (state_q == S_DONE) || (state_q == S_ERR);
  assign pslverr_o   = (state_q == S_ERR);
  assign prdata_o    = ((state_q == S_DONE) && !write_q) ? prdata_q : 32'd0;

endmodule

// File: tb/tb_dmac_apb_slave_if.sv
// Bench for dmac_apb_slave_if: two instances (no wait states / three wait states), a table of
// directed transfers, hand-written abort/reset sequences and random transfers vs a transaction model.
module tb_dmac_apb_slave_if;

  localparam int WAIT_OF [2] = '{0, 3};
  localparam int NREGS = 4;
`ifdef DMAC_APB_WRPROT_EN
  localparam bit WRPROT = 1'b1;
`else
  localparam bit WRPROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        psel [2];
  logic        penable [2];
  logic        pwrite [2];
  logic [11:0] paddr [2];
  logic [31:0] pwdata [2];
  logic [31:0] prdata [2];
  logic        pready [2];
  logic        pslverr [2];
  logic [1:0]  reg_idx [2];
  logic        reg_wren [2];
  logic        reg_rden [2];
  logic [31:0] reg_wdata [2];
  logic [31:0] reg_rdata [2];
`ifdef DMAC_APB_WRPROT_EN
  logic        lock [2];
`endif

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    dmac_apb_slave_if #(
      .ADDR_W(12),
      .NUM_REGS(NREGS),
      .WAIT_CYCLES(WAIT_OF[gi])
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .psel_i     (psel[gi]),
      .penable_i  (penable[gi]),
      .pwrite_i   (pwrite[gi]),
      .paddr_i    (paddr[gi]),
      .pwdata_i   (pwdata[gi]),
      .prdata_o   (prdata[gi]),
      .pready_o   (pready[gi]),
      .pslverr_o  (pslverr[gi]),
      .reg_idx_o  (reg_idx[gi]),
      .reg_wren_o (reg_wren[gi]),
      .reg_rden_o (reg_rden[gi]),
      .reg_wdata_o(reg_wdata[gi]),
`ifdef DMAC_APB_WRPROT_EN
      .lock_i     (lock[gi]),
`endif
      .reg_rdata_i(reg_rdata[gi])
    );
  end

  // Register block stand-in: registered read; junk on the bus whenever no read was strobed
  logic [31:0] env_mem [2][4] = '{default: '0};
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reg_wren[d]) env_mem[d][reg_idx[d]] <= reg_wdata[d];
      reg_rdata[d] <= reg_rden[d] ? env_mem[d][reg_idx[d]] : $urandom();
    end
  end

  int          wr_cnt [2] = '{0, 0};
  int          rd_cnt [2] = '{0, 0};
  int          rdy_cnt [2] = '{0, 0};
  logic [1:0]  last_idx [2] = '{2'd0, 2'd0};
  logic [31:0] last_wdata [2] = '{32'd0, 32'd0};
  logic        both_seen = 1'b0;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reg_wren[d]) begin
        wr_cnt[d]     <= wr_cnt[d] + 1;
        last_idx[d]   <= reg_idx[d];
        last_wdata[d] <= reg_wdata[d];
      end
      if (reg_rden[d]) begin
        rd_cnt[d]   <= rd_cnt[d] + 1;
        last_idx[d] <= reg_idx[d];
      end
      if (pready[d]) rdy_cnt[d] <= rdy_cnt[d] + 1;
      if (reg_wren[d] && reg_rden[d]) both_seen <= 1'b1;
    end
  end

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] ref_regs [2][4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Entered and left at posedge+1; leaves psel low so a following call is back-to-back.
  task automatic apb_xfer(input int d, input bit wr, input logic [11:0] addr,
                          input logic [31:0] data, input bit lk,
                          output logic [31:0] rdata, output logic err, output int cycles);
    bit done = 1'b0;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = data;
`ifdef DMAC_APB_WRPROT_EN
    lock[d] = lk;
`endif
    rdata = 32'hx; err = 1'bx; cycles = 0;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (pready[d]) begin
        done  = 1'b1;
        rdata = prdata[d];
        err   = pslverr[d];
      end
      @(posedge clk); #1;
    end
    psel[d] = 1'b0; penable[d] = 1'b0;
    chk("xfer_complete", 32'(done), 32'd1);
  endtask

  task automatic check_xfer(input int d, input bit wr, input logic [11:0] addr,
                            input logic [31:0] data, input bit lk, input bit exp_err,
                            input int exp_cyc, input logic [31:0] exp_rd);
    int wr0 = wr_cnt[d];
    int rd0 = rd_cnt[d];
    int cyc;
    logic [31:0] rd;
    logic er;
    apb_xfer(d, wr, addr, data, lk, rd, er, cyc);
    $display("xfer dut%0d %s addr=0x%03h wdata=0x%08h lock=%0b -> cycles=%0d slverr=%0b rdata=0x%08h",
             d, wr ? "WR" : "RD", addr, data, lk, cyc, er, rd);
    chk("pslverr", 32'(er), 32'(exp_err));
    chk("access_cycles", 32'(cyc), 32'(exp_cyc));
    chk("prdata", rd, exp_rd);
    chk("wren_count", 32'(wr_cnt[d] - wr0), (wr && !exp_err) ? 32'd1 : 32'd0);
    chk("rden_count", 32'(rd_cnt[d] - rd0), (!wr && !exp_err) ? 32'd1 : 32'd0);
    if (!exp_err) begin
      chk("reg_idx", 32'(last_idx[d]), 32'(addr[3:2]));
      if (wr) chk("reg_wdata", last_wdata[d], data);
    end
    chk("strobe_overlap", 32'(both_seen), 32'd0);
    if (wr && !exp_err) ref_regs[d][addr[3:2]] = data;
  endtask

  // Transaction-level expectations computed straight from the address map rules
  function automatic bit model_err(bit wr, logic [11:0] addr, bit lk);
    return (addr % 4 != 0) || (addr / 4 >= NREGS) || (WRPROT && wr && lk);
  endfunction

  task automatic model_xfer(input int d, input bit wr, input logic [11:0] addr,
                            input logic [31:0] data, input bit lk);
    bit e = model_err(wr, addr, lk);
    int cyc = e ? 1 : ((wr ? 2 : 3) + WAIT_OF[d]);
    logic [31:0] rexp = (!e && !wr) ? ref_regs[d][addr / 4] : 32'd0;
    check_xfer(d, wr, addr, data, lk, e, cyc, rexp);
  endtask

  typedef struct {
    int          d;
    bit          wr;
    logic [11:0] addr;
    logic [31:0] data;
    bit          exp_err;
    int          exp_cyc;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int r0, y0;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
`ifdef DMAC_APB_WRPROT_EN
      lock[d] = 1'b0;
`endif
      for (int i = 0; i < 4; i++) ref_regs[d][i] = '0;
    end

    tbl[0] = '{0, 1'b1, 12'h004, 32'h0123_4567, 1'b0, 2, 32'h0};
    tbl[1] = '{0, 1'b0, 12'h004, 32'h0,         1'b0, 3, 32'h0123_4567};
    tbl[2] = '{0, 1'b1, 12'h006, 32'h1111_2222, 1'b1, 1, 32'h0};
    tbl[3] = '{0, 1'b0, 12'h010, 32'h0,         1'b1, 1, 32'h0};
    tbl[4] = '{0, 1'b1, 12'h00C, 32'hDEAD_BEEF, 1'b0, 2, 32'h0};
    tbl[5] = '{0, 1'b0, 12'h00C, 32'h0,         1'b0, 3, 32'hDEAD_BEEF};
    tbl[6] = '{1, 1'b1, 12'h008, 32'hA5A5_5A5A, 1'b0, 5, 32'h0};
    tbl[7] = '{1, 1'b0, 12'h008, 32'h0,         1'b0, 6, 32'hA5A5_5A5A};
    tbl[8] = '{1, 1'b0, 12'h000, 32'h0,         1'b0, 6, 32'h0};
    tbl[9] = '{1, 1'b0, 12'hFFC, 32'h0,         1'b1, 1, 32'h0};

    // Reset held for three cycles: every output at its reset value
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_pready", 32'(pready[d]), 32'd0);
      chk("rst_pslverr", 32'(pslverr[d]), 32'd0);
      chk("rst_prdata", prdata[d], 32'd0);
      chk("rst_strobes", 32'({reg_wren[d], reg_rden[d]}), 32'd0);
      chk("rst_reg_idx", 32'(reg_idx[d]), 32'd0);
      chk("rst_reg_wdata", reg_wdata[d], 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("idle_no_strobe", 32'(wr_cnt[0] + rd_cnt[0] + wr_cnt[1] + rd_cnt[1]), 32'd0);
    chk("idle_no_pready", 32'(rdy_cnt[0] + rdy_cnt[1]), 32'd0);

    // Directed table; entries 6..7 run back-to-back on the wait-state instance
    for (int i = 0; i < 10; i++)
      check_xfer(tbl[i].d, tbl[i].wr, tbl[i].addr, tbl[i].data, 1'b0,
                 tbl[i].exp_err, tbl[i].exp_cyc, tbl[i].exp_rd);

    // Access phase with no setup phase is ignored
    r0 = wr_cnt[0] + rd_cnt[0]; y0 = rdy_cnt[0];
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 12'h004;
    repeat (4) @(posedge clk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    repeat (2) @(posedge clk); #1;
    $display("seq dut0 access-without-setup");
    chk("nosetup_strobe", 32'(wr_cnt[0] + rd_cnt[0] - r0), 32'd0);
    chk("nosetup_pready", 32'(rdy_cnt[0] - y0), 32'd0);

    // psel dropped while waiting: abort, no strobe, no pready
    r0 = wr_cnt[1] + rd_cnt[1]; y0 = rdy_cnt[1];
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 12'h004; pwdata[1] = 32'hCAFE_0001;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    repeat (6) @(posedge clk); #1;
    $display("seq dut1 psel-abort-in-wait");
    chk("abort_strobe", 32'(wr_cnt[1] + rd_cnt[1] - r0), 32'd0);
    chk("abort_pready", 32'(rdy_cnt[1] - y0), 32'd0);
    model_xfer(1, 1'b0, 12'h004, 32'h0, 1'b0);

    // Reset asserted while waiting
    r0 = wr_cnt[1] + rd_cnt[1]; y0 = rdy_cnt[1];
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 12'h00C; pwdata[1] = 32'h7777_8888;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_reg_idx", 32'(reg_idx[1]), 32'd0);
    chk("midrst_reg_wdata", reg_wdata[1], 32'd0);
    chk("midrst_pready", 32'(pready[1]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    psel[1] = 1'b0; penable[1] = 1'b0;
    repeat (5) @(posedge clk); #1;
    $display("seq dut1 reset-in-wait");
    chk("midrst_strobe", 32'(wr_cnt[1] + rd_cnt[1] - r0), 32'd0);
    chk("midrst_pready_after", 32'(rdy_cnt[1] - y0), 32'd0);
    model_xfer(1, 1'b1, 12'h00C, 32'h1357_9BDF, 1'b0);
    model_xfer(1, 1'b0, 12'h00C, 32'h0, 1'b0);

`ifdef DMAC_APB_WRPROT_EN
    model_xfer(0, 1'b1, 12'h008, 32'hBAD0_BAD0, 1'b1);
    model_xfer(0, 1'b0, 12'h008, 32'h0, 1'b1);
    model_xfer(0, 1'b0, 12'h00C, 32'h0, 1'b1);
`endif

    // Random traffic against the transaction model
    for (int n = 0; n < 80; n++) begin
      int d = $urandom_range(0, 1);
      bit wr = 1'($urandom_range(0, 1));
      bit lk = WRPROT ? 1'($urandom_range(0, 1)) : 1'b0;
      logic [11:0] addr;
      case ($urandom_range(0, 3))
        0, 1:    addr = 12'($urandom_range(0, NREGS - 1) * 4);
        2:       addr = 12'($urandom_range(0, 19));
        default: addr = 12'($urandom());
      endcase
      model_xfer(d, wr, addr, $urandom(), lk);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
